rr_logging_flush_ctrl: RTL

RR_LOGGING_FLUSH_CTRL -- requirements
Module: rr_logging_flush_ctrl

---
 rtl/rr_logging_flush_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/rr_logging_flush_ctrl.sv
// rr_logging_flush_ctrl
//   Session controller for the round-robin trace logger. A start pulse opens
//   a logging session (RUN). A stop pulse closes capture and drains the
//   packed merge tree (DRAIN). DONE is reached once every pipeline stage has
//   been seen empty while the tree was flowing. Two saturating statistics
//   counters record the accepted non-empty beats and their summed length.
//
//   Optional feature macro: RR_FLUSH_TIMEOUT_EN
//     When defined, DRAIN is also bounded by TIMEOUT_CYCLES. If the bound
//     expires first, the block leaves DRAIN and sets a sticky timeout flag.
//     When undefined, timeout is tied to 0.
//
// Ports
//   clk         in   sole clock, rising edge
//   rstn        in   asynchronous active-low reset
//   start       in   pulse: open a new session (from IDLE or DONE)
//   stop        in   pulse: end the session and flush (from RUN)
//   tree_valid  in   any_valid from the top of the merge tree
//   tree_len    in   len from the top of the merge tree
//   sink_ready  in   downstream trace-writer ready
//   tree_ready  out  ready into the packing block (RUN/DRAIN only)
//   log_en      out  channel capture enable (RUN only)
//   busy        out  session active (RUN or DRAIN)
//   done        out  flush complete (DONE)
//   timeout     out  sticky drain-timeout flag
//   pkt_cnt     out  accepted non-empty beats (saturating)
//   bit_cnt     out  sum of tree_len over accepted beats (saturating)
//
// tree_len is assumed to be no wider than the counters (OFFSET_WIDTH <= CNT_WIDTH).
module rr_logging_flush_ctrl #(
  parameter int OFFSET_WIDTH   = 10,
  parameter int PIPE_DEPTH     = 4,
  parameter int CNT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    tree_valid,
  input  logic [OFFSET_WIDTH-1:0] tree_len,
  input  logic                    sink_ready,
  output logic                    tree_ready,
  output logic                    log_en,
  output logic                    busy,
  output logic                    done,
  output logic                    timeout,
  output logic [CNT_WIDTH-1:0]    pkt_cnt,
  output logic [CNT_WIDTH-1:0]    bit_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // The idle counter must be able to hold PIPE_DEPTH+1.
  localparam int IDLE_W = $clog2(PIPE_DEPTH + 2);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(PIPE_DEPTH + 1);

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic [CNT_WIDTH-1:0]  bit_cnt_q, bit_cnt_d;
  logic [IDLE_W-1:0]     idle_cnt_q, idle_cnt_d;
  logic                  busy_s;
  logic                  tree_ready_s;
  logic                  accept_s;
  logic [CNT_WIDTH:0]    bit_sum_s;

`ifdef RR_FLUSH_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
  logic [TO_W-1:0]       drain_cnt_q, drain_cnt_d;
  logic                  timeout_q, timeout_d;
`else
  // TIMEOUT_CYCLES has no effect in this build.
  localparam int timeout_cycles_unused = TIMEOUT_CYCLES;
`endif

  // Handshake qualifiers derived from the state register.
  always_comb begin
    busy_s       = (state_q == S_RUN) || (state_q == S_DRAIN);
    tree_ready_s = sink_ready && busy_s;
    // Empty beats (len 0) flow through but are not counted.
    accept_s     = tree_valid && tree_ready_s && (tree_len != {OFFSET_WIDTH{1'b0}});
    // One extra bit so a carry out signals saturation.
    bit_sum_s    = {1'b0, bit_cnt_q} + {{(CNT_WIDTH + 1 - OFFSET_WIDTH){1'b0}}, tree_len};
  end

  // Next-state, counter and drain-tracking logic.
  always_comb begin
    state_d    = state_q;
    pkt_cnt_d  = pkt_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    idle_cnt_d = {IDLE_W{1'b0}};
`ifdef RR_FLUSH_TIMEOUT_EN
    drain_cnt_d = {TO_W{1'b0}};
    timeout_d   = timeout_q;
`endif

    if (accept_s) begin
      if (pkt_cnt_q != {CNT_WIDTH{1'b1}}) begin
        pkt_cnt_d = pkt_cnt_q + {{(CNT_WIDTH - 1){1'b0}}, 1'b1};
      end else begin
        pkt_cnt_d = pkt_cnt_q;
      end
      if (bit_sum_s[CNT_WIDTH]) begin
        bit_cnt_d = {CNT_WIDTH{1'b1}};
      end else begin
        bit_cnt_d = bit_sum_s[CNT_WIDTH-1:0];
      end
    end else begin
      pkt_cnt_d = pkt_cnt_q;
      bit_cnt_d = bit_cnt_q;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        // start wins over a simultaneous stop here; stop alone is ignored.
        if (start) begin
          state_d   = S_RUN;
          pkt_cnt_d = {CNT_WIDTH{1'b0}};
          bit_cnt_d = {CNT_WIDTH{1'b0}};
`ifdef RR_FLUSH_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
        end else begin
          state_d = state_q;
        end
      end
      S_RUN: begin
        // stop wins over a simultaneous start; the idle counter enters DRAIN at 0.
        if (stop) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        // Only cycles where the tree is flowing and empty count toward the flush.
        if (tree_ready_s && !tree_valid) begin
          idle_cnt_d = idle_cnt_q + {{(IDLE_W - 1){1'b0}}, 1'b1};
        end else begin
          idle_cnt_d = {IDLE_W{1'b0}};
        end
`ifdef RR_FLUSH_TIMEOUT_EN
        drain_cnt_d = drain_cnt_q + {{(TO_W - 1){1'b0}}, 1'b1};
        // A clean flush on the same edge as the timeout takes precedence.
        if (idle_cnt_d == IDLE_LIMIT) begin
          state_d = S_DONE;
        end else if (drain_cnt_d == TO_LIMIT) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end else begin
          state_d = S_DRAIN;
        end
`else
        if (idle_cnt_d == IDLE_LIMIT) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
`endif
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      pkt_cnt_q  <= {CNT_WIDTH{1'b0}};
      bit_cnt_q  <= {CNT_WIDTH{1'b0}};
      idle_cnt_q <= {IDLE_W{1'b0}};
`ifdef RR_FLUSH_TIMEOUT_EN
      drain_cnt_q <= {TO_W{1'b0}};
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pkt_cnt_q  <= pkt_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      idle_cnt_q <= idle_cnt_d;
`ifdef RR_FLUSH_TIMEOUT_EN
      drain_cnt_q <= drain_cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign tree_ready = tree_ready_s;
  assign log_en     = (state_q == S_RUN);
  assign busy       = busy_s;
  assign done       = (state_q == S_DONE);
  assign pkt_cnt    = pkt_cnt_q;
  assign bit_cnt    = bit_cnt_q;
`ifdef RR_FLUSH_TIMEOUT_EN
  assign timeout    = timeout_q;
`else
  assign timeout    = 1'b0;
`endif

endmodule
